sqrt_sched: RTL and testbench

- Shares one sqrt32 integer square-root engine (16-iteration, bit-serial, one result per run) between N_REQ requesters, e.g. per-channel RMS units of the scope computation path.
- Arbitrates round-robin and launches the engine by pulsing its reset with a stable operand.
- Captures the one-cycle ready strobe and returns the 16-bit root tagged with the requester index.
- Guards against a stuck engine with a cycle timeout.

---
 rtl/sqrt_sched_pkg.sv | 17 +
 rtl/sqrt_sched_rr_arbiter.sv | 34 +++
 rtl/sqrt_sched.sv | 165 ++++++++++++++++
 tb/tb_sqrt_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the sqrt32 engine scheduler.
package sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int ENG_ITER = 16;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sqrt_sched_rr_arbiter.sv
// Round-robin picker: searches upward from ptr and wraps, one-hot grant gated by en.
module rr_arbiter
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             any_req
);

    logic found;

    always_comb begin
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = ID_W'(idx);
            end
        end
    end

    assign any_req = found;
    assign grant   = (en && found) ? (N_REQ'(1) << id) : '0;

endmodule

// File: rtl/sqrt_sched.sv
// Shares one external sqrt32 engine between N_REQ requesters: round-robin launch,
// tagged result capture and a stuck-engine timeout.
module sqrt_sched
    import sqrt_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = id_width(N_REQ),
    parameter int TIMEOUT = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*32-1:0] req_x,
    output logic                busy,
    output logic [N_REQ-1:0]    grant,
    output logic                res_valid,
    output logic [ID_W-1:0]     res_id,
    output logic [15:0]         res_y,
    output logic                res_err,
    output logic                eng_reset,
    output logic [31:0]         eng_x,
    input  logic                eng_rdy,
    input  logic [15:0]         eng_y
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       eng_x_q, eng_x_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [15:0]       res_y_q, res_y_d;
    logic              res_err_q, res_err_d;
    logic              busy_q, busy_d;
    logic              eng_reset_q, eng_reset_d;
    logic              live_q, live_d;

    logic [N_REQ-1:0]  served_mask;
    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]   arb_id;
    logic              arb_any;
    logic              arb_en;
    logic              accept;

    // The requester just served still holds req in DONE; it has not seen res_valid yet.
    always_comb begin
        served_mask = '0;
        if (state_q == DONE) begin
            served_mask[id_q] = 1'b1;
        end
    end

    assign arb_req = req & ~served_mask;
    assign arb_en  = live_q && ((state_q == IDLE) || (state_q == DONE));
    assign accept  = arb_en && arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (ptr_q),
        .en      (arb_en),
        .grant   (arb_grant),
        .id      (arb_id),
        .any_req (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        eng_x_d     = eng_x_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_y_d     = res_y_q;
        res_err_d   = res_err_q;
        live_d      = 1'b1;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = LOAD;
                    id_d    = arb_id;
                    eng_x_d = req_x[int'(arb_id)*32 +: 32];
                    ptr_d   = (arb_id == ID_LAST) ? '0 : arb_id + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (eng_rdy) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_id_d    = id_q;
                    res_y_d     = eng_y;
                    res_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_id_d    = id_q;
                    res_y_d     = '0;
                    res_err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        eng_reset_d = (state_d != RUN);
    end

    // live_q holds off arbitration until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            eng_x_q     <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_y_q     <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            eng_reset_q <= 1'b1;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            eng_x_q     <= eng_x_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_y_q     <= res_y_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
            eng_reset_q <= eng_reset_d;
            live_q      <= live_d;
        end
    end

    assign busy      = busy_q;
    assign grant     = arb_grant;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_y     = res_y_q;
    assign res_err   = res_err_q;
    assign eng_reset = eng_reset_q;
    assign eng_x     = eng_x_q;

endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: behavioural sqrt32 engine, vector table and scoreboard of
// expected grants/results with latency checks.
module tb_sqrt_sched;
    import sqrt_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 20;
    localparam int LAT     = ENG_ITER + 2;
    localparam int LAT_TO  = TIMEOUT + 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*32-1:0] req_x = '0;
    logic                busy;
    logic [N_REQ-1:0]    grant;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [15:0]         res_y;
    logic                res_err;
    logic                eng_reset;
    logic [31:0]         eng_x;
    logic                eng_rdy;
    logic [15:0]         eng_y;

    logic stuck = 1'b0;
    logic spur  = 1'b0;

    typedef struct {
        int          id;
        logic [15:0] y;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    exp_t sb_q[$];
    int   grant_exp_q[$];
    int   grant_cyc_q[$];

    int errors  = 0;
    int checks  = 0;
    int results = 0;
    int grants  = 0;
    int cycle   = 0;

    logic [N_REQ-1:0] auto_drop = '1;
    bit check_spacing = 1'b0;
    bit have_last     = 1'b0;
    int last_res_cycle = 0;

    sqrt_sched #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_x     (req_x),
        .busy      (busy),
        .grant     (grant),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_y     (res_y),
        .res_err   (res_err),
        .eng_reset (eng_reset),
        .eng_x     (eng_x),
        .eng_rdy   (eng_rdy),
        .eng_y     (eng_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Engine model: cleared while eng_reset is high, ready on the 16th free-running cycle.
    logic [31:0] m_x = '0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (eng_reset) begin
            m_x   <= eng_x;
            m_cnt <= 0;
        end else if (m_cnt < ENG_ITER) begin
            m_cnt <= m_cnt + 1;
        end
    end

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if ({16'd0, t} * {16'd0, t} <= x) r = t;
        end
        return r;
    endfunction

    assign eng_y   = isqrt(m_x);
    assign eng_rdy = ((m_cnt == ENG_ITER - 1) && !eng_reset && !stuck) || spur;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name, input int actual, input int expected);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic pushExpect(input int id, input logic [15:0] y, input logic err,
                              input int lat);
        exp_t e;
        e.id  = id;
        e.y   = y;
        e.err = err;
        e.lat = lat;
        sb_q.push_back(e);
        grant_exp_q.push_back(id);
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] x, input logic [15:0] y,
                                 input logic err, input int lat);
        req_x[id*32 +: 32] = x;
        req[id] = 1'b1;
        pushExpect(id, y, err, lat);
    endtask

    task automatic waitResults(input int target, input int budget);
        int n;
        n = 0;
        while (results < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (results < target) failEvent("wait_results", results, target);
    endtask

    task automatic waitGrants(input int target, input int budget);
        int n;
        n = 0;
        while (grants < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (grants < target) failEvent("wait_grants", grants, target);
    endtask

    // Monitor: pops the scoreboard on res_valid, checks grants against expected order.
    initial begin
        exp_t e;
        int   gc;
        int   ge;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                grant_cyc_q.delete();
            end else begin
                if (res_valid) begin
                    if (sb_q.size() == 0) begin
                        failEvent("res_unexpected", 32'(res_id), -1);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("res_id", 32'(res_id), 32'(e.id));
                        checkOutput("res_y", 32'(res_y), 32'(e.y));
                        checkOutput("res_err", 32'(res_err), 32'(e.err));
                        if (grant_cyc_q.size() > 0) begin
                            gc = grant_cyc_q.pop_front();
                            checkOutput("latency", 32'(cycle - gc), 32'(e.lat));
                        end else begin
                            failEvent("latency_nogrant", 0, 1);
                        end
                        if (check_spacing && have_last) begin
                            checkOutput("spacing", 32'(cycle - last_res_cycle), 32'(LAT));
                        end
                        last_res_cycle = cycle;
                        have_last = 1'b1;
                        if (auto_drop[e.id]) req[e.id] = 1'b0;
                    end
                    results++;
                end
                if (grant != '0) begin
                    grants++;
                    checkOutput("grant_state", 32'(busy && !res_valid), 32'd0);
                    if (grant_exp_q.size() == 0) begin
                        failEvent("grant_unexpected", 32'(grant), 0);
                    end else begin
                        ge = grant_exp_q.pop_front();
                        checkOutput("grant", 32'(grant), 32'd1 << ge);
                    end
                    grant_cyc_q.push_back(cycle);
                end
            end
        end
    end

    initial begin
        vec_t vecs[8];
        int   base;

        vecs[0] = '{2, 32'd1000000,    16'd1000};
        vecs[1] = '{0, 32'd0,          16'd0};
        vecs[2] = '{1, 32'hFFFF_FFFF,  16'd65535};
        vecs[3] = '{3, 32'd15,         16'd3};
        vecs[4] = '{0, 32'd16,         16'd4};
        vecs[5] = '{2, 32'd1,          16'd1};
        vecs[6] = '{1, 32'd99,         16'd9};
        vecs[7] = '{3, 32'd65536,      16'd256};

        // Reset state, with every requester asserting to show grant is held off.
        req = '1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_id", 32'(res_id), 32'd0);
        checkOutput("rst_res_y", 32'(res_y), 32'd0);
        checkOutput("rst_res_err", 32'(res_err), 32'd0);
        checkOutput("rst_eng_reset", 32'(eng_reset), 32'd1);
        checkOutput("rst_eng_x", eng_x, 32'd0);
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single requests from the table; the last entry leaves the pointer at 0.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i].id, vecs[i].x, vecs[i].y, 1'b0, LAT);
            waitResults(i + 1, 60);
        end

        // All four at once: served 0,1,2,3, one result per LAT clocks.
        @(posedge clk);
        #1;
        check_spacing = 1'b1;
        have_last     = 1'b0;
        base = results;
        applyStimulus(0, 32'd4,  16'd2, 1'b0, LAT);
        applyStimulus(1, 32'd9,  16'd3, 1'b0, LAT);
        applyStimulus(2, 32'd16, 16'd4, 1'b0, LAT);
        applyStimulus(3, 32'd25, 16'd5, 1'b0, LAT);
        waitResults(base + 4, 200);
        check_spacing = 1'b0;

        // Fairness: requesters 0 and 3 held high alternate; dropping mid-run still completes.
        @(posedge clk);
        #1;
        auto_drop = 4'b0110;
        base = results;
        req_x[0*32 +: 32] = 32'd49;
        req_x[3*32 +: 32] = 32'd144;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) pushExpect(0, 16'd7, 1'b0, LAT);
            else            pushExpect(3, 16'd12, 1'b0, LAT);
        end
        req[0] = 1'b1;
        req[3] = 1'b1;
        waitGrants(grants + 6, 300);
        #1;
        req[0] = 1'b0;
        req[3] = 1'b0;
        waitResults(base + 6, 100);
        auto_drop = '1;
        repeat (4) @(posedge clk);

        // Spurious ready while idle must not produce a completion.
        base = results;
        #1;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("spur_busy", 32'(busy), 32'd0);
        checkOutput("spur_results", 32'(results), 32'(base));

        // Stuck engine times out with an error, then a normal request recovers.
        stuck = 1'b1;
        base = results;
        applyStimulus(1, 32'd81, 16'd0, 1'b1, LAT_TO);
        waitResults(base + 1, 60);
        @(posedge clk);
        #1;
        stuck = 1'b0;
        applyStimulus(2, 32'd36, 16'd6, 1'b0, LAT);
        waitResults(base + 2, 60);

        // Reset asserted in the 8th RUN cycle aborts silently.
        @(posedge clk);
        #1;
        base = results;
        req_x[0*32 +: 32] = 32'd10000;
        req[0] = 1'b1;
        grant_exp_q.push_back(0);
        waitGrants(grants + 1, 40);
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_eng_reset", 32'(eng_reset), 32'd1);
        checkOutput("mid_rst_grant", 32'(grant), 32'd0);
        checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_res_y", 32'(res_y), 32'd0);
        checkOutput("mid_rst_res_id", 32'(res_id), 32'd0);
        checkOutput("mid_rst_eng_x", eng_x, 32'd0);
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        checkOutput("mid_rst_no_result", 32'(results), 32'(base));
        applyStimulus(0, 32'd10000, 16'd100, 1'b0, LAT);
        waitResults(base + 1, 60);
        repeat (5) @(posedge clk);
        #1;

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("grant_q_empty", 32'(grant_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
